// File: rtl/muxn_cfg_loader.sv
// Serial configuration loader for a bank of select-mux trees.
// Config words are shifted bit-serially into a shadow chain. The shadow is copied
// to the live sel_bus only after the whole chain has been loaded, so the routing
// bank never sees a partially loaded configuration.
module muxn_cfg_loader #(
    parameter int unsigned SWIDTH  = 5,
    parameter int unsigned NUM_MUX = 8,
    parameter int unsigned WORD_W  = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic                        abort,
    input  logic [WORD_W-1:0]           in_data,
    input  logic                        in_valid,
    output logic                        in_ready,
    output logic [NUM_MUX*SWIDTH-1:0]   sel_bus,
    output logic                        busy,
    output logic                        done
);

    localparam int unsigned ChainLen = NUM_MUX * SWIDTH;
    localparam int unsigned BitsW    = $clog2(ChainLen + 1);
    localparam int unsigned CntW     = $clog2(WORD_W + 1);

    typedef enum logic [1:0] {StIdle, StLoad, StShift, StCommit} state_e;

    state_e              state_q, state_d;
    logic [ChainLen-1:0] shadow_q, shadow_d;
    logic [ChainLen-1:0] sel_q, sel_d;
    logic [WORD_W-1:0]   buf_q, buf_d;
    logic [BitsW-1:0]    bits_left_q, bits_left_d;
    logic [CntW-1:0]     shift_cnt_q, shift_cnt_d;
    logic                done_q, done_d;

    // State and datapath registers; sel_bus only ever moves via sel_d in StCommit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            shadow_q    <= '0;
            sel_q       <= '0;
            buf_q       <= '0;
            bits_left_q <= '0;
            shift_cnt_q <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            shadow_q    <= shadow_d;
            sel_q       <= sel_d;
            buf_q       <= buf_d;
            bits_left_q <= bits_left_d;
            shift_cnt_q <= shift_cnt_d;
            done_q      <= done_d;
        end
    end

    // Next-state logic: abort wins over every other action outside StIdle.
    always_comb begin
        state_d     = state_q;
        shadow_d    = shadow_q;
        sel_d       = sel_q;
        buf_d       = buf_q;
        bits_left_d = bits_left_q;
        shift_cnt_d = shift_cnt_q;
        done_d      = 1'b0;
        in_ready    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start && !abort) begin
                    state_d     = StLoad;
                    bits_left_d = BitsW'(ChainLen);
                end
            end
            StLoad: begin
                if (abort) begin
                    state_d  = StIdle;
                    shadow_d = '0;
                end else begin
                    in_ready = 1'b1;
                    if (in_valid) begin
                        buf_d   = in_data;
                        state_d = StShift;
                        // Last word may be partial: only bits still owed to the chain are shifted.
                        if (32'(bits_left_q) >= WORD_W) begin
                            shift_cnt_d = CntW'(WORD_W);
                        end else begin
                            shift_cnt_d = CntW'(bits_left_q);
                        end
                    end
                end
            end
            StShift: begin
                if (abort) begin
                    state_d  = StIdle;
                    shadow_d = '0;
                end else begin
                    shadow_d    = {buf_q[0], shadow_q[ChainLen-1:1]};
                    buf_d       = buf_q >> 1;
                    shift_cnt_d = shift_cnt_q - CntW'(1);
                    bits_left_d = bits_left_q - BitsW'(1);
                    if (shift_cnt_q == CntW'(1)) begin
                        state_d = (bits_left_q == BitsW'(1)) ? StCommit : StLoad;
                    end
                end
            end
            StCommit: begin
                state_d = StIdle;
                if (abort) begin
                    shadow_d = '0;
                end else begin
                    sel_d  = shadow_q;
                    done_d = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign sel_bus = sel_q;
    assign busy    = (state_q != StIdle);
    assign done    = done_q;

endmodule

// File: tb/tb_muxn_cfg_loader.sv
// Directed bench for muxn_cfg_loader: a table of full loads on the default
// configuration, plus hand sequences for abort, ignored start, a 16-bit word
// variant and asynchronous reset during a load.
module tb_muxn_cfg_loader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, abort, in_valid;
    logic [7:0]  in_data;
    logic        in_ready, busy, done;
    logic [39:0] sel_bus;

    logic        s16, a16, v16;
    logic [15:0] d16;
    logic        r16, b16, dn16;
    logic [39:0] sel16;

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int d16_cnt = 0;
    int d16_cyc = 0;

    muxn_cfg_loader dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .abort    (abort),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .sel_bus  (sel_bus),
        .busy     (busy),
        .done     (done)
    );

    muxn_cfg_loader #(.WORD_W(16)) dut16 (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (s16),
        .abort    (a16),
        .in_data  (d16),
        .in_valid (v16),
        .in_ready (r16),
        .sel_bus  (sel16),
        .busy     (b16),
        .done     (dn16)
    );

    always #5 clk = ~clk;

    // Edge counter used to time done relative to the start-sampling edge.
    always @(posedge clk) cyc <= cyc + 1;

    // Done monitors, sampled on the falling edge.
    always @(negedge clk) begin
        if (done) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
        end
        if (dn16) begin
            d16_cnt = d16_cnt + 1;
            d16_cyc = cyc;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk = n_chk + 1;
        if (act !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_chk = n_chk + 1;
        n_err = n_err + 1;
        $display("FAIL %s: timed out waiting, expected event", name);
    endtask

    task automatic wait_ready(input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) timeout(name);
    endtask

    // Full 5-word load on the default instance. gap = idle LOAD cycles before each
    // word; poke_start pulses start during the first SHIFT; abort_at aborts after
    // that word's handshake (-1 = no abort).
    task automatic do_load(input logic [39:0] words, input int gap, input bit poke_start,
                           input int abort_at, output int lat, output int ndone);
        int  d0 = done_cnt;
        int  s_cyc;
        bit  aborted = 1'b0;
        bit  got = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        s_cyc = cyc;
        start = 1'b0;
        for (int w = 0; w < 5; w++) begin
            if (!aborted) begin
                wait_ready("wait_in_ready");
                repeat (gap) @(negedge clk);
                in_data  = words[w*8 +: 8];
                in_valid = 1'b1;
                @(negedge clk);
                in_valid = 1'b0;
                if (poke_start && w == 0) begin
                    start = 1'b1;
                    @(negedge clk);
                    start = 1'b0;
                end
                if (w == abort_at) begin
                    abort = 1'b1;
                    @(negedge clk);
                    abort   = 1'b0;
                    aborted = 1'b1;
                end
            end
        end
        if (!aborted) begin
            for (int i = 0; i < 300; i++) begin
                if (done_cnt != d0) begin
                    got = 1'b1;
                    break;
                end
                @(negedge clk);
            end
            if (!got) timeout("wait_done");
            repeat (5) @(negedge clk);
        end
        lat   = done_cyc - s_cyc;
        ndone = done_cnt - d0;
    endtask

    typedef struct {
        logic [39:0] words;
        int          gap;
        logic [39:0] exp_sel;
        logic [4:0]  exp_mux0;
        int          exp_lat;
    } vec_t;

    vec_t tbl[4];

    initial begin
        int lat, nd, d0, s_cyc;
        bit got;

        tbl[0] = '{words: 40'h0123456789, gap: 1, exp_sel: 40'h0123456789,
                   exp_mux0: 5'h09, exp_lat: 51};
        tbl[1] = '{words: 40'h8967452301, gap: 0, exp_sel: 40'h8967452301,
                   exp_mux0: 5'h01, exp_lat: 46};
        tbl[2] = '{words: 40'h8967452301, gap: 3, exp_sel: 40'h8967452301,
                   exp_mux0: 5'h01, exp_lat: 61};
        tbl[3] = '{words: 40'hFFFFFFFFFF, gap: 0, exp_sel: 40'hFFFFFFFFFF,
                   exp_mux0: 5'h1F, exp_lat: 46};

        rst_n = 1'b0;
        start = 1'b0; abort = 1'b0; in_valid = 1'b0; in_data = '0;
        s16 = 1'b0; a16 = 1'b0; v16 = 1'b0; d16 = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_sel_bus", 64'(sel_bus), 64'h0);
        chk("reset_busy", 64'(busy), 64'h0);
        chk("reset_in_ready", 64'(in_ready), 64'h0);
        chk("reset_done", 64'(done), 64'h0);

        // Table of full loads
        for (int i = 0; i < 4; i++) begin
            do_load(tbl[i].words, tbl[i].gap, 1'b0, -1, lat, nd);
            chk($sformatf("v%0d_sel_bus", i), 64'(sel_bus), 64'(tbl[i].exp_sel));
            chk($sformatf("v%0d_mux0", i), 64'(sel_bus[4:0]), 64'(tbl[i].exp_mux0));
            chk($sformatf("v%0d_done_edge", i), 64'(lat), 64'(tbl[i].exp_lat));
            chk($sformatf("v%0d_done_pulses", i), 64'(nd), 64'd1);
            chk($sformatf("v%0d_busy_after", i), 64'(busy), 64'h0);
        end

        // Abort after word 2 with all-ones committed
        d0 = done_cnt;
        do_load(40'h1122334455, 0, 1'b0, 1, lat, nd);
        chk("abort_busy_next", 64'(busy), 64'h0);
        chk("abort_sel_kept", 64'(sel_bus), 64'hFF_FFFF_FFFF);
        repeat (60) @(negedge clk);
        chk("abort_no_done", 64'(done_cnt - d0), 64'd0);
        chk("abort_sel_kept_late", 64'(sel_bus), 64'hFF_FFFF_FFFF);
        do_load(40'h2222222222, 0, 1'b0, -1, lat, nd);
        chk("post_abort_sel", 64'(sel_bus), 64'h22_2222_2222);
        chk("post_abort_done_edge", 64'(lat), 64'd46);

        // start during SHIFT is ignored
        do_load(40'hA5C3E10F96, 0, 1'b1, -1, lat, nd);
        chk("poke_sel", 64'(sel_bus), 64'hA5_C3E1_0F96);
        chk("poke_done_edge", 64'(lat), 64'd46);
        chk("poke_done_pulses", 64'(nd), 64'd1);
        chk("poke_idle_after", 64'(busy), 64'h0);

        // start+abort together in IDLE is ignored
        d0 = done_cnt;
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        chk("start_abort_busy", 64'(busy), 64'h0);
        chk("start_abort_in_ready", 64'(in_ready), 64'h0);
        repeat (50) @(negedge clk);
        chk("start_abort_no_done", 64'(done_cnt - d0), 64'd0);

        // In LOAD, abort gates in_ready combinationally
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("load_in_ready", 64'(in_ready), 64'h1);
        abort = 1'b1;
        #1;
        chk("load_abort_in_ready", 64'(in_ready), 64'h0);
        @(negedge clk);
        abort = 1'b0;
        chk("load_abort_busy", 64'(busy), 64'h0);

        // 16-bit word variant: partial last word
        d0 = d16_cnt;
        s16 = 1'b1;
        @(posedge clk);
        #1;
        s_cyc = cyc;
        s16 = 1'b0;
        for (int w = 0; w < 3; w++) begin
            got = 1'b0;
            for (int i = 0; i < 100; i++) begin
                @(negedge clk);
                if (r16) begin
                    got = 1'b1;
                    break;
                end
            end
            if (!got) timeout("w16_wait_ready");
            d16 = (w == 0) ? 16'h1111 : (w == 1) ? 16'h2222 : 16'hAB33;
            v16 = 1'b1;
            @(negedge clk);
            v16 = 1'b0;
        end
        got = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (d16_cnt != d0) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!got) timeout("w16_wait_done");
        repeat (5) @(negedge clk);
        chk("w16_sel_bus", 64'(sel16), 64'h33_2222_1111);
        chk("w16_done_edge", 64'(d16_cyc - s_cyc), 64'd44);
        chk("w16_done_pulses", 64'(d16_cnt - d0), 64'd1);

        // Asynchronous reset mid-SHIFT after a prior commit
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        in_data  = 8'hA5;
        in_valid = 1'b1;
        repeat (12) @(negedge clk);
        chk("pre_reset_busy", 64'(busy), 64'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_sel_bus", 64'(sel_bus), 64'h0);
        chk("async_reset_busy", 64'(busy), 64'h0);
        chk("async_reset_in_ready", 64'(in_ready), 64'h0);
        chk("async_reset_done", 64'(done), 64'h0);
        chk("async_reset_sel16", 64'(sel16), 64'h0);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_reset_idle", 64'(busy), 64'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
